// File: rtl/fila_instrucoes.sv
// Instruction queue: circular buffer feeding a reservation station through a
// three-state issue FSM (IDLE -> ISSUE -> WAIT), at most one issue per 3 cycles.
module fila_instrucoes #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [WIDTH-1:0]         instIn,
    input  logic                     instInValid,
    input  logic                     flush,
    input  logic                     disponivel,
    output logic [WIDTH-1:0]         instruction,
    output logic                     enableInstr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              issuedCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_instruction;
    logic             r_enable;
    logic             r_overflow;
    logic [15:0]      r_issued;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == S_IDLE) && !w_empty && disponivel && !flush;
    // A full queue still accepts a push when the same edge frees the head slot.
    assign w_push  = instInValid && !flush && (!w_full || w_pop);
    assign w_drop  = instInValid && !flush && w_full && !w_pop;

    // Storage needs no reset: instruction only ever loads entries already written.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_tail] <= instIn;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_state       <= S_IDLE;
            r_instruction <= '0;
            r_enable      <= 1'b0;
            r_overflow    <= 1'b0;
            r_issued      <= '0;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
            r_issued   <= '0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head        <= (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
                r_instruction <= r_mem[r_head];
                r_issued      <= r_issued + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state  <= S_ISSUE;
                        r_enable <= 1'b1;
                    end else begin
                        r_enable <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state  <= S_WAIT;
                    r_enable <= 1'b0;
                end
                S_WAIT: begin
                    r_state  <= S_IDLE;
                    r_enable <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = r_instruction;
    assign enableInstr = r_enable;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign issuedCount = r_issued;

endmodule

// File: tb/tb_fila_instrucoes.sv
// Bench for fila_instrucoes: queue-based reference model with an issue cooldown,
// issued words checked by an independent scoreboard monitor.
module tb_fila_instrucoes;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic             Clock = 1'b0;
    logic             Resetn;
    logic [WIDTH-1:0] instIn;
    logic             instInValid;
    logic             flush;
    logic             disponivel;
    logic [WIDTH-1:0] instruction;
    logic             enableInstr;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic [15:0]      issuedCount;

    fila_instrucoes #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .instIn      (instIn),
        .instInValid (instInValid),
        .flush       (flush),
        .disponivel  (disponivel),
        .instruction (instruction),
        .enableInstr (enableInstr),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .issuedCount (issuedCount)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue contents plus cycles left before another issue.
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    int          m_busy;
    bit          m_ovf;
    bit          m_en;
    logic [15:0] m_issued;
    logic [15:0] m_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy   = 0;
        m_ovf    = 1'b0;
        m_en     = 1'b0;
        m_issued = '0;
        m_instr  = '0;
    endtask

    task automatic model_edge();
        int  sz;
        bit  pop;
        sz = mq.size();
        if (flush) begin
            mq.delete();
            m_busy   = 0;
            m_ovf    = 1'b0;
            m_issued = '0;
            m_en     = 1'b0;
        end else begin
            pop = (m_busy == 0) && (sz > 0) && disponivel;
            if (pop) begin
                m_busy   = 2;
                m_instr  = mq.pop_front();
                m_issued = m_issued + 16'd1;
                sb.push_back(m_instr);
            end else if (m_busy > 0) begin
                m_busy--;
            end
            m_en = pop;
            if (instInValid) begin
                if (sz < DEPTH || pop) mq.push_back(instIn);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("count",       32'(count),       32'(mq.size()));
        chk("empty",       32'(empty),       32'(mq.size() == 0));
        chk("full",        32'(full),        32'(mq.size() == DEPTH));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("issuedCount", 32'(issuedCount), 32'(m_issued));
        chk("enableInstr", 32'(enableInstr), 32'(m_en));
        chk("instruction", 32'(instruction), 32'(m_instr));
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit f, input bit disp);
        instInValid = v;
        instIn      = d;
        flush       = f;
        disponivel  = disp;
    endtask

    // Scoreboard monitor: every issue strobe must match the oldest expected word.
    always @(negedge Clock) begin
        if (Resetn && enableInstr) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got %0h expected none at %0t", instruction, $time);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (instruction !== e) begin
                    n_fail++;
                    $display("FAIL issue_word: got %0h expected %0h at %0t", instruction, e, $time);
                end
            end
        end
    end

    initial begin
        Resetn = 1'b0;
        drive(0, '0, 0, 0);
        model_reset();
        #1;
        check_outputs();
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        check_outputs();

        // Two pushes back to back, issued three cycles apart
        drive(1, 16'h1C01, 0, 1); step();
        drive(1, 16'h2281, 0, 1); step();
        drive(0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step();
        chk("two_issued", 32'(issuedCount), 32'd2);
        chk("two_empty",  32'(empty),       32'd1);

        // Fill with station busy, overflow on 9th push, then drain in order
        for (int i = 0; i < 9; i++) begin
            drive(1, 16'hA000 + 16'(i), 0, 0); step();
        end
        chk("fill_count",    32'(count),    32'd8);
        chk("fill_overflow", 32'(overflow), 32'd1);
        drive(0, '0, 0, 1);
        for (int i = 0; i < 30; i++) step();

        // Flush clears overflow; refill, then push on the issue edge while full
        drive(0, '0, 1, 0); step();
        for (int i = 0; i < 8; i++) begin
            drive(1, 16'hB000 + 16'(i), 0, 0); step();
        end
        drive(1, 16'hBEEF, 0, 1); step();
        chk("fullpop_count",    32'(count),    32'd8);
        chk("fullpop_overflow", 32'(overflow), 32'd0);
        drive(0, '0, 0, 1);
        for (int i = 0; i < 30; i++) step();

        // Station goes busy during WAIT for 5 cycles
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'hC000 + 16'(i), 0, 1); step();
        end
        drive(0, '0, 0, 1);
        for (int i = 0; i < 6 && m_busy != 1; i++) step();
        chk("reached_wait", 32'(m_busy), 32'd1);
        drive(0, '0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        drive(0, '0, 0, 1); step();
        chk("issue_after_rise", 32'(enableInstr), 32'd1);
        for (int i = 0; i < 10; i++) step();

        // Flush wins over a simultaneous push and issue
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'hD000 + 16'(i), 0, 0); step();
        end
        drive(1, 16'hDEAD, 1, 1); step();
        chk("flush_count",  32'(count),       32'd0);
        chk("flush_empty",  32'(empty),       32'd1);
        chk("flush_en",     32'(enableInstr), 32'd0);
        chk("flush_issued", 32'(issuedCount), 32'd0);

        // Asynchronous reset while an issue strobe is high
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'hE000 + 16'(i), 0, 1); step();
        end
        drive(0, '0, 0, 1);
        for (int i = 0; i < 6 && !m_en; i++) step();
        chk("pre_reset_en", 32'(enableInstr), 32'd1);
        @(negedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        sb.delete();
        chk("async_en", 32'(enableInstr), 32'd0);
        check_outputs();
        drive(0, '0, 0, 0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        check_outputs();

        // Ten pushes with continuous issue, wrapping the pointers
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'hF000 + 16'(i), 0, 1); step();
        end
        drive(0, '0, 0, 1);
        for (int i = 0; i < 30; i++) step();
        chk("wrap_issued", 32'(issuedCount), 32'd10);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 65);
            step();
        end
        drive(0, '0, 0, 1);
        for (int i = 0; i < 40; i++) step();
        @(negedge Clock);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fila_instrucoes.md
FILA_INSTRUCOES -- requirements
Module: fila_instrucoes

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the queue depth in entries (power of two, 2..16).
REQ-002 The module SHALL have parameter WIDTH, default 16, giving the instruction width in bits.
REQ-003 Port: Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: Resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port: instIn  input  WIDTH  instruction word to enqueue.
REQ-006 Port: instInValid  input  1  push request for instIn this cycle.
REQ-007 Port: flush  input  1  synchronous clear of queue contents and issue state.
REQ-008 Port: disponivel  input  1  reservation station has at least one free entry.
REQ-009 Port: instruction  output  WIDTH  instruction being issued to the reservation station.
REQ-010 Port: enableInstr  output  1  issue strobe; instruction is valid while high.
REQ-011 Port: full  output  1  count equals DEPTH.
REQ-012 Port: empty  output  1  count equals 0.
REQ-013 Port: count  output  log2(DEPTH)+1  number of queued entries.
REQ-014 Port: overflow  output  1  sticky flag: a push was dropped because the queue was full.
REQ-015 Port: issuedCount  output  16  number of instructions issued since reset or flush.

Function
REQ-016 Storage SHALL be a circular buffer with head/tail pointers that wrap from DEPTH-1 to 0; entries issue in push order.
REQ-017 The issue FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-018 In IDLE with count>0, disponivel=1 and flush=0, the next edge SHALL go to ISSUE, load instruction with the head entry, set enableInstr=1, advance head and decrement count.
REQ-019 In IDLE when any condition in REQ-018 is not met, the FSM SHALL stay in IDLE and hold enableInstr=0.
REQ-020 ISSUE SHALL last exactly one cycle: the next edge SHALL go to WAIT and clear enableInstr.
REQ-021 WAIT SHALL last exactly one cycle, then return to IDLE; disponivel is ignored in WAIT so the station's Busy update settles.
REQ-022 Maximum issue rate SHALL be one instruction per 3 cycles; enableInstr SHALL never be high on two consecutive cycles.
REQ-023 instruction SHALL hold its last issued value while enableInstr=0.
REQ-024 A push SHALL be accepted when instInValid=1, flush=0, and either count<DEPTH or a pop occurs on the same edge.
REQ-025 Push and pop on the same edge SHALL leave count unchanged and keep data order intact, including when full.
REQ-026 A push rejected as in REQ-024 (full, no pop) SHALL set overflow=1 and leave queue contents unchanged.
REQ-027 issuedCount SHALL increment by 1 on every edge entering ISSUE and wrap from 16'hFFFF to 0.
REQ-028 flush=1 SHALL on the next edge:
  - zero count, head and tail
  - clear overflow and issuedCount
  - force state IDLE and enableInstr=0
  - take priority over a simultaneous push and issue (both are dropped).
REQ-029 full, empty and count SHALL be combinational from registered state and SHALL change only at clock edges.

Reset
REQ-030 While Resetn=0, the following SHALL be forced immediately, independent of Clock: state=IDLE, enableInstr=0, instruction=0, count=0, head=tail=0, overflow=0, issuedCount=0, empty=1, full=0.
REQ-031 Reset asserted mid-issue SHALL discard all queued entries; after release, the first issue SHALL occur no earlier than the second edge after a push.
REQ-032 Storage array contents SHALL NOT need reset; they SHALL never be visible on instruction before being written.

Verification
REQ-033 Reset, then push 16'h1C01 and 16'h2281 on consecutive cycles with disponivel=1 -> enableInstr pulses with 16'h1C01, then 16'h2281 three cycles later, each pulse exactly one cycle wide; issuedCount=2, empty=1.
REQ-034 Push 8 words with disponivel=0 -> full=1, count=8; a 9th push -> overflow=1, count stays 8; set disponivel=1 -> all 8 words issue in order.
REQ-035 Full queue, push on the same edge an issue pops -> count stays 8, overflow stays 0, and the new word issues last.
REQ-036 Drop disponivel to 0 during WAIT, keep it low 5 cycles, then raise it -> no issue while low; the issue occurs on the edge after it rises.
REQ-037 Queue holding 3 entries, assert flush on the same cycle as a push and an IDLE->ISSUE condition -> next cycle count=0, empty=1, enableInstr=0, issuedCount=0.
REQ-038 Assert Resetn=0 asynchronously while enableInstr=1 -> enableInstr falls before the next Clock edge; pushes 10 words across a wrap with pointer wrap verified by in-order output.
